// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Steps an N_IN-bit input vector through every code in ascending order. Each
// code is held for SETTLE+1 cycles. On the edge that ends the hold window, the
// block samples a sum-of-products output and a product-of-sums output of the
// same function. The samples are packed into two truth-table words. A sticky
// flag records the lowest code at which the two forms disagree.
//
// Ports:
//   clk        clock, rising-edge
//   rst        asynchronous active-high reset
//   start      begin a sweep (accepted in IDLE or DONE only)
//   vec        vector driven to the function under test (vec[N_IN-1] = a)
//   sop_in     sum-of-products output of the function under test
//   pos_in     product-of-sums output of the function under test
//   busy       sweep in progress
//   done       sweep complete; held until the next accepted start or reset
//   table_sop  captured sop_in; bit k corresponds to vec==k
//   table_pos  captured pos_in; bit k corresponds to vec==k
//   mismatch   sticky; the two forms disagreed somewhere in this sweep
//   first_bad  lowest disagreeing code; meaningful only when mismatch=1
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_IN-1:0]         vec,
  input  logic                    sop_in,
  input  logic                    pos_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    table_sop,
  output logic [(1<<N_IN)-1:0]    table_pos,
  output logic                    mismatch,
  output logic [N_IN-1:0]         first_bad
);

  localparam int unsigned TW       = 1 << N_IN;
  localparam logic [7:0]  SETTLE_L = 8'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q,   cnt_d;
  logic [N_IN-1:0]   vec_q,   vec_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [TW-1:0]     tsop_q,  tsop_d;
  logic [TW-1:0]     tpos_q,  tpos_d;
  logic              mis_q,   mis_d;
  logic [N_IN-1:0]   fb_q,    fb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tsop_q  <= '0;
      tpos_q  <= '0;
      mis_q   <= 1'b0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tsop_q  <= tsop_d;
      tpos_q  <= tpos_d;
      mis_q   <= mis_d;
      fb_q    <= fb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tsop_d  = tsop_q;
    tpos_d  = tpos_q;
    mis_d   = mis_q;
    fb_d    = fb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HOLD;
          cnt_d   = SETTLE_L;
          vec_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          tsop_d  = '0;
          tpos_d  = '0;
          mis_d   = 1'b0;
          fb_d    = '0;
        end
      end

      // The counter is loaded with SETTLE. HOLD therefore lasts SETTLE cycles,
      // and SAMPLE adds one more. A code stays on vec for SETTLE+1 cycles in
      // total.
      S_HOLD: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        tsop_d[vec_q] = sop_in;
        tpos_d[vec_q] = pos_in;
        // Codes are visited in ascending order, so the first disagreement
        // seen is also the lowest.
        if ((sop_in != pos_in) && !mis_q) begin
          mis_d = 1'b1;
          fb_d  = vec_q;
        end
        if (vec_q == '1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
          vec_d   = vec_q + N_IN'(1);
          cnt_d   = SETTLE_L;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_sop = tsop_q;
  assign table_pos = tpos_q;
  assign mismatch  = mis_q;
  assign first_bad = fb_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper.
// Two instances run side by side:
//   dut3  N_IN=3, SETTLE=1, driven by a 3-input SOP/POS pair with selectable
//         faults.
//   dut4  N_IN=4, SETTLE=3, driven by f = a&b | c^d.
// A time-based reference model gives the expected value of every output. The
// model uses the number of cycles elapsed since the accepted start. A single
// compare process checks both instances against it on every falling edge.
`timescale 1ns/1ps
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst, start3, start4;
  logic [2:0]  vec3, first_bad3;
  logic [3:0]  vec4, first_bad4;
  logic        sop3, pos3, sop4, pos4;
  logic        busy3, done3, mismatch3, busy4, done4, mismatch4;
  logic [7:0]  table_sop3, table_pos3;
  logic [15:0] table_sop4, table_pos4;

  int n_chk  = 0;
  int n_fail = 0;
  int mode3  = 0;    // 0 agree, 1 pos tied 0, 2 pos inverted at code 5
  int sel3_m = 0;    // mode captured when the current dut3 sweep started
  int t3 = -1;       // cycles since the accepted start; -1 when reset/idle
  int t4 = -1;
  int len;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vec(vec3),
    .sop_in(sop3), .pos_in(pos3), .busy(busy3), .done(done3),
    .table_sop(table_sop3), .table_pos(table_pos3),
    .mismatch(mismatch3), .first_bad(first_bad3)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .vec(vec4),
    .sop_in(sop4), .pos_in(pos4), .busy(busy4), .done(done4),
    .table_sop(table_sop4), .table_pos(table_pos4),
    .mismatch(mismatch4), .first_bad(first_bad4)
  );

  // Reference functions. sel 0..2 select the 3-input pair; sel 3 selects the
  // 4-input function.
  function automatic bit fsop(int sel, int k);
    bit a, b, c, d;
    if (sel == 3) begin
      a = k[3]; b = k[2]; c = k[1]; d = k[0];
      return (a & b) | (c ^ d);
    end
    a = k[2]; b = k[1]; c = k[0];
    return (!a && !b) || (!b && c) || (b && !c);
  endfunction

  function automatic bit fpos(int sel, int k);
    bit a, b, c, d, p;
    if (sel == 3) begin
      a = k[3]; b = k[2]; c = k[1]; d = k[0];
      return (a & b) | (c ^ d);
    end
    a = k[2]; b = k[1]; c = k[0];
    p = (!a || b || c) && (!b || !c);
    if (sel == 1) return 1'b0;
    if (sel == 2) return p ^ (k == 5);
    return p;
  endfunction

  assign sop3 = fsop(mode3, int'(vec3));
  assign pos3 = fpos(mode3, int'(vec3));
  assign sop4 = fsop(3, int'(vec4));
  assign pos4 = fpos(3, int'(vec4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs after t cycles of a sweep of n inputs and settle s.
  task automatic calc(input int n, input int s, input int t, input int sel,
                      output logic [63:0] v, output logic [63:0] b,
                      output logic [63:0] d, output logic [63:0] ts,
                      output logic [63:0] tp, output logic [63:0] m,
                      output logic [63:0] fb);
    int codes, nd;
    v = '0; b = '0; d = '0; ts = '0; tp = '0; m = '0; fb = '0;
    if (t >= 0) begin
      codes = 1 << n;
      nd    = t / (s + 1);
      if (nd > codes) nd = codes;
      if (t < codes * (s + 1)) begin
        v = 64'(t / (s + 1));
        b = 64'd1;
      end else begin
        v = 64'(codes - 1);
        d = 64'd1;
      end
      for (int k = 0; k < nd; k++) begin
        ts[k] = fsop(sel, k);
        tp[k] = fpos(sel, k);
        if (ts[k] != tp[k] && m == 64'd0) begin
          m  = 64'd1;
          fb = 64'(k);
        end
      end
    end
  endtask

  // Model timebase: counts cycles from the accepted start, saturating at done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t3 = -1;
      t4 = -1;
    end else begin
      if (start3 && (t3 < 0 || t3 >= 16)) begin
        t3 = 0;
        sel3_m = mode3;
      end else if (t3 >= 0 && t3 < 16) begin
        t3++;
      end
      if (start4 && (t4 < 0 || t4 >= 64)) t4 = 0;
      else if (t4 >= 0 && t4 < 64) t4++;
    end
  end

  always @(negedge clk) begin : cmp
    logic [63:0] ev, eb, ed, ets, etp, em, efb;
    calc(3, 1, t3, sel3_m, ev, eb, ed, ets, etp, em, efb);
    chk("vec3", 64'(vec3), ev);
    chk("busy3", 64'(busy3), eb);
    chk("done3", 64'(done3), ed);
    chk("table_sop3", 64'(table_sop3), ets);
    chk("table_pos3", 64'(table_pos3), etp);
    chk("mismatch3", 64'(mismatch3), em);
    chk("first_bad3", 64'(first_bad3), efb);
    calc(4, 3, t4, 3, ev, eb, ed, ets, etp, em, efb);
    chk("vec4", 64'(vec4), ev);
    chk("busy4", 64'(busy4), eb);
    chk("done4", 64'(done4), ed);
    chk("table_sop4", 64'(table_sop4), ets);
    chk("table_pos4", 64'(table_pos4), etp);
    chk("mismatch4", 64'(mismatch4), em);
    chk("first_bad4", 64'(first_bad4), efb);
  end

  // Pulse start for dut3, confirm the start state, then count edges to done.
  task automatic sweep3(input int m, output int n);
    @(posedge clk); #2 start3 = 1'b1; mode3 = m;
    @(posedge clk); #2 start3 = 1'b0;
    chk("start_vec3", 64'(vec3), 64'd0);
    chk("start_busy3", 64'(busy3), 64'd1);
    chk("start_done3", 64'(done3), 64'd0);
    chk("start_tables3", 64'({table_sop3, table_pos3, mismatch3}), 64'd0);
    n = 0;
    while (!done3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("idle3", 64'({busy3, done3, vec3}), 64'd0);

    // Matching SOP/POS pair.
    sweep3(0, len);
    chk("len3_agree", 64'(len), 64'd16);
    chk("tsop3_agree", 64'(table_sop3), 64'h67);
    chk("tpos3_agree", 64'(table_pos3), 64'h67);
    chk("mis3_agree", 64'(mismatch3), 64'd0);

    // Restart from DONE with pos tied low: the first disagreement is at code 0.
    sweep3(1, len);
    chk("len3_tied", 64'(len), 64'd16);
    chk("mis3_tied", 64'(mismatch3), 64'd1);
    chk("fb3_tied", 64'(first_bad3), 64'd0);
    chk("tpos3_tied", 64'(table_pos3), 64'h00);

    // A single fault at code 5.
    sweep3(2, len);
    chk("mis3_f5", 64'(mismatch3), 64'd1);
    chk("fb3_f5", 64'(first_bad3), 64'd5);
    chk("tpos3_f5", 64'(table_pos3), 64'h47);

    // N_IN=4, SETTLE=3, with start pulses while busy.
    @(posedge clk); #2 start4 = 1'b1;
    @(posedge clk); #2 start4 = 1'b0;
    chk("start_busy4", 64'(busy4), 64'd1);
    len = 0;
    while (!done4 && len < 400) begin
      @(posedge clk); #1;
      len++;
      start4 = (len == 10 || len == 11 || len == 37);
    end
    start4 = 1'b0;
    chk("len4", 64'(len), 64'd64);
    chk("tsop4", 64'(table_sop4), 64'hF666);
    chk("tpos4", 64'(table_pos4), 64'hF666);
    chk("mis4", 64'(mismatch4), 64'd0);

    // Reset in the middle of a sweep.
    @(posedge clk); #2 start3 = 1'b1; mode3 = 0;
    @(posedge clk); #2 start3 = 1'b0;
    len = 0;
    while (vec3 != 3'd5 && len < 200) begin
      @(posedge clk); #1;
      len++;
    end
    chk("reach_vec5", 64'(vec3), 64'd5);
    #1 rst = 1'b1;
    #1 chk("rst_async3", 64'({vec3, busy3, done3, table_sop3, table_pos3,
                              mismatch3, first_bad3}), 64'd0);
    chk("rst_async4", 64'({vec4, busy4, done4, table_sop4, table_pos4,
                           mismatch4, first_bad4}), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #2 chk("post_rst_idle3", 64'({busy3, done3, vec3, table_sop3}), 64'd0);
    sweep3(0, len);
    chk("len3_after_rst", 64'(len), 64'd16);
    chk("tsop3_after_rst", 64'(table_sop3), 64'h67);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesizable stimulus-and-capture engine for small combinational logic blocks. It drives an N-input test vector through every code from 0 to 2^N-1. After a programmable settle time it samples two candidate outputs of the same function: a sum-of-products form and a product-of-sums form. It packs both into truth-table words and flags the lowest input code at which the two forms disagree. It sits on the response side of the combinational gate-level function modules, so their equivalence can be checked in hardware or in a self-checking bench without `$monitor` inspection.

## Interface
Parameters:
- N_IN, 4, number of function inputs; legal range 1..6.
- SETTLE, 1, number of idle hold cycles after each vector change before sampling; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a sweep when sampled high in IDLE or DONE; ignored while busy.
- vec  output  N_IN  vector driven to the function inputs; vec[N_IN-1] is the leftmost literal (a), vec[0] the rightmost.
- sop_in  input  1  sum-of-products implementation output.
- pos_in  input  1  product-of-sums implementation output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or reset.
- table_sop  output  2^N_IN  captured sop_in values; bit k is the output for vec==k.
- table_pos  output  2^N_IN  captured pos_in values; bit k is the output for vec==k.
- mismatch  output  1  sticky flag, set if sop_in!=pos_in for any vector in the current sweep.
- first_bad  output  N_IN  lowest vec at which a mismatch occurred; valid only when mismatch=1.

## Operation
- States: IDLE, HOLD, SAMPLE, DONE.
- Reset, asynchronous and effective immediately: the block enters IDLE and clears every output to 0, including vec, busy, done, both tables, mismatch and first_bad.
- IDLE or DONE with start=1: on the next edge the block enters HOLD and does the following.
  - vec=0, busy=1, done=0.
  - Both tables, mismatch and first_bad are cleared to 0.
  - The hold counter is loaded with SETTLE.
- HOLD: the hold counter decrements once per cycle. When it reaches 0 the block goes to SAMPLE; vec is unchanged.
- SAMPLE edge:
  - table_sop[vec] <= sop_in and table_pos[vec] <= pos_in.
  - If sop_in!=pos_in and mismatch==0: mismatch <= 1 and first_bad <= vec.
  - If sop_in!=pos_in and mismatch is already 1: first_bad is not updated. The lowest index wins because codes are swept ascending.
  - If vec < 2^N_IN-1: vec increments, the counter reloads SETTLE, and the block returns to HOLD.
  - If vec == 2^N_IN-1 (wrap boundary): vec holds its final value, busy=0, done=1, and the block goes to DONE. vec never wraps to 0 inside a sweep.
- DONE: the tables, mismatch and first_bad hold their values until the next accepted start or reset.
- start while busy is ignored, with no effect on vec, the counter or the tables.
- Reset mid-sweep aborts the sweep with no partial results retained.
- Arithmetic:
  - vec counter width is N_IN, and the terminal-count compare is against all ones.
  - Hold counter width is 8 bits.
  - Table bit indexing uses vec as an unsigned index.

## Timing
- Each vector is held on vec for exactly SETTLE+1 cycles. The inputs are sampled on the edge that ends that hold window.
- Start latency: vec=0 and busy=1 are visible one cycle after the edge that samples start.
- Sweep length: 2^N_IN*(SETTLE+1) cycles from busy rising to done rising.
- busy and done are never high together; the busy-to-done transition happens on a single edge.
- sop_in and pos_in must be stable (combinational outputs of vec) at the sampling edge. No synchronizers are included.

## Test plan
- **SOP/POS agree, N_IN=3:** N_IN=3, SETTLE=1. Connect sop_in to !A!B+!BC+B!C and pos_in to (!A+B+C)(!B+!C) over a,b,c=vec[2:0], then pulse start.
  - Required: table_sop=8'h67, table_pos=8'h67, mismatch=0, done=1 exactly 16 cycles after busy rises.
- **Forced disagreement:** same setup, but tie pos_in=0.
  - Required: mismatch=1 and first_bad=3'd0. Inject a fault only at vec=5 instead: first_bad=3'd5.
- **Settle timing, N_IN=4:** N_IN=4, SETTLE=3, sweep a 4-input function.
  - Required: each vec value is held exactly 4 cycles, and done rises 64 cycles after busy.
  - Required: table bit k equals the function value at k for all 16 codes.
- **Reset mid-sweep:** assert rst while vec=5.
  - Required: all outputs read 0 in the same cycle, asynchronously.
  - Required: after rst drops, the block stays idle until start, and a new sweep restarts at vec=0.
- **start during busy and restart after DONE:**
  - Required: start pulses during busy leave vec progression and total length unchanged.
  - Required: a start in DONE clears the tables, mismatch and done, then re-sweeps from vec=0.
